// File: rtl/mips32_multicycle.sv
`default_nettype none
// ============================================================================
//  Module   : mips32_multicycle
//  Purpose  : Multicycle MIPS32 integer-subset core. Each instruction walks
//             FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB). Instructions come
//             from an external memory over a req/valid handshake. The core
//             holds its own register file and data memory, and halts on
//             BREAK, exposing the BREAK rs value on result.
//  Ports    : clock, reset      - clock, synchronous active-high reset
//             imem_req/addr     - fetch request and word address (out)
//             imem_valid/data   - fetch response, sampled while imem_req high
//             halted, result    - halt flag and value captured at BREAK
//             retired           - completed-instruction counter (wraps)
//             illegal           - sticky unsupported-encoding flag
//  Revision : 1.0 - initial release
// ============================================================================
module mips32_multicycle #(
   parameter int          IMEM_AW  = 6,
   parameter int          DMEM_AW  = 7,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic               clock,
   input  logic               reset,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_valid,
   input  logic [31:0]        imem_data,
   output logic               halted,
   output logic [31:0]        result,
   output logic [31:0]        retired,
   output logic               illegal
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_HALT    = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [31:0] r_pc;
   logic [31:0] r_pc4;
   logic [31:0] r_ir;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_imm;
   logic [31:0] r_alu;
   logic [31:0] r_mdr;
   logic        r_halted;
   logic [31:0] r_result;
   logic [31:0] r_retired;
   logic        r_illegal;

   logic [31:0] r_rf   [32];
   logic [31:0] r_dmem [2**DMEM_AW];

   // ------------------------------------------------------------------------
   // Instruction field decode (from the latched IR)
   // ------------------------------------------------------------------------
   logic [5:0]  w_op;
   logic [5:0]  w_funct;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [4:0]  w_shamt;
   logic        w_is_r;
   logic        w_r_alu;
   logic        w_brk;
   logic        w_addi;
   logic        w_andi;
   logic        w_ori;
   logic        w_lw;
   logic        w_sw;
   logic        w_beq;
   logic        w_bne;
   logic        w_j;
   logic        w_i_alu;
   logic        w_any_alu;
   logic        w_legal;

   assign w_op    = r_ir[31:26];
   assign w_funct = r_ir[5:0];
   assign w_rs    = r_ir[25:21];
   assign w_rt    = r_ir[20:16];
   assign w_rd    = r_ir[15:11];
   assign w_shamt = r_ir[10:6];

   assign w_is_r  = (w_op == 6'd0);
   assign w_r_alu = w_is_r && ((w_funct == 6'd32) || (w_funct == 6'd34) ||
                               (w_funct == 6'd36) || (w_funct == 6'd37) ||
                               (w_funct == 6'd42) || (w_funct == 6'd0)  ||
                               (w_funct == 6'd2));
   assign w_brk   = w_is_r && (w_funct == 6'd13);
   assign w_addi  = (w_op == 6'd8);
   assign w_andi  = (w_op == 6'd12);
   assign w_ori   = (w_op == 6'd13);
   assign w_lw    = (w_op == 6'd35);
   assign w_sw    = (w_op == 6'd43);
   assign w_beq   = (w_op == 6'd4);
   assign w_bne   = (w_op == 6'd5);
   assign w_j     = (w_op == 6'd2);

   assign w_i_alu   = w_addi || w_andi || w_ori;
   assign w_any_alu = w_r_alu || w_i_alu;
   assign w_legal   = w_any_alu || w_brk || w_lw || w_sw || w_beq || w_bne || w_j;

   // Register reads; $0 is forced to zero regardless of array contents
   logic [31:0] w_rs_val;
   logic [31:0] w_rt_val;
   assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
   assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];

   // andi/ori take a zero-extended immediate, everything else sign-extends
   logic [31:0] w_imm;
   assign w_imm = (w_andi || w_ori) ? {16'h0, r_ir[15:0]}
                                    : {{16{r_ir[15]}}, r_ir[15:0]};

   // ------------------------------------------------------------------------
   // ALU / address generation
   // ------------------------------------------------------------------------
   logic [31:0] w_alu;
   always_comb begin
      w_alu = r_a + r_imm;
      if (w_is_r) begin
         case (w_funct)
            6'd34:   w_alu = r_a - r_b;
            6'd36:   w_alu = r_a & r_b;
            6'd37:   w_alu = r_a | r_b;
            6'd42:   w_alu = {31'd0, $signed(r_a) < $signed(r_b)};
            6'd0:    w_alu = r_b << w_shamt;
            6'd2:    w_alu = r_b >> w_shamt;
            default: w_alu = r_a + r_b;
         endcase
      end else if (w_andi) begin
         w_alu = r_a & r_imm;
      end else if (w_ori) begin
         w_alu = r_a | r_imm;
      end
   end

   logic        w_taken;
   logic [31:0] w_br_tgt;
   logic [31:0] w_j_tgt;
   assign w_taken  = (w_beq && (r_a == r_b)) || (w_bne && (r_a != r_b));
   assign w_br_tgt = r_pc4 + {r_imm[29:0], 2'b00};
   assign w_j_tgt  = {r_pc4[31:28], r_ir[25:0], 2'b00};

   logic [DMEM_AW-1:0] w_dm_idx;
   logic [4:0]         w_dst;
   assign w_dm_idx = r_alu[DMEM_AW+1:2];
   assign w_dst    = w_is_r ? w_rd : w_rt;

   // ------------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   logic w_retire;
   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (imem_valid) begin
               w_next = S_DECODE;
            end
         end
         S_DECODE: w_next = S_EXECUTE;
         S_EXECUTE: begin
            if (w_any_alu) begin
               w_next = S_WB;
            end else if (w_lw || w_sw) begin
               w_next = S_MEM;
            end else if (w_brk) begin
               w_next   = S_HALT;
               w_retire = 1'b1;
            end else begin
               // branches, jump and illegal encodings all finish here
               w_next   = S_FETCH;
               w_retire = 1'b1;
            end
         end
         S_MEM: begin
            if (w_lw) begin
               w_next = S_WB;
            end else begin
               w_next   = S_FETCH;
               w_retire = 1'b1;
            end
         end
         S_WB: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_FETCH;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath and architectural state
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc      <= RESET_PC;
         r_pc4     <= '0;
         r_ir      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_imm     <= '0;
         r_alu     <= '0;
         r_mdr     <= '0;
         r_halted  <= 1'b0;
         r_result  <= '0;
         r_retired <= '0;
         r_illegal <= 1'b0;
         for (int i = 0; i < 32; i++) begin
            r_rf[i] <= '0;
         end
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem_valid) begin
                  r_ir <= imem_data;
               end
            end
            S_DECODE: begin
               r_a   <= w_rs_val;
               r_b   <= w_rt_val;
               r_imm <= w_imm;
               r_pc4 <= r_pc + 32'd4;
            end
            S_EXECUTE: begin
               r_alu <= w_alu;
               if (w_beq || w_bne) begin
                  r_pc <= w_taken ? w_br_tgt : r_pc4;
               end else if (w_j) begin
                  r_pc <= w_j_tgt;
               end else if (w_brk) begin
                  r_result <= r_a;
                  r_halted <= 1'b1;
               end else if (!w_legal) begin
                  r_illegal <= 1'b1;
                  r_pc      <= r_pc4;
               end
            end
            S_MEM: begin
               if (w_lw) begin
                  r_mdr <= r_dmem[w_dm_idx];
               end else begin
                  r_pc <= r_pc4;
               end
            end
            S_WB: begin
               if (w_dst != 5'd0) begin
                  r_rf[w_dst] <= w_lw ? r_mdr : r_alu;
               end
               r_pc <= r_pc4;
            end
            default: ;
         endcase
         if (w_retire) begin
            r_retired <= r_retired + 32'd1;
         end
      end
   end

   // Data memory keeps its contents across reset; a reset edge still
   // suppresses any store that would otherwise land on it.
   always_ff @(posedge clock) begin
      if (!reset && (r_state == S_MEM) && w_sw) begin
         r_dmem[w_dm_idx] <= r_b;
      end
   end

   assign imem_req  = (r_state == S_FETCH) && !reset;
   assign imem_addr = r_pc[IMEM_AW+1:2];
   assign halted    = r_halted;
   assign result    = r_result;
   assign retired   = r_retired;
   assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_mips32_multicycle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips32_multicycle
//  Purpose  : Self-checking bench for mips32_multicycle. An instruction-level
//             reference model predicts result, retired count, illegal flag,
//             cycle count and the fetch address trace of each program.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips32_multicycle;

   localparam int IMEM_AW = 6;
   localparam int DMEM_AW = 7;
   localparam int LIMIT   = 3000;

   logic               clock      = 1'b0;
   logic               reset      = 1'b1;
   logic               imem_valid = 1'b0;
   logic [31:0]        imem_data  = 32'd0;
   logic               imem_req;
   logic [IMEM_AW-1:0] imem_addr;
   logic               halted;
   logic [31:0]        result;
   logic [31:0]        retired;
   logic               illegal;

   always #5 clock = ~clock;

   mips32_multicycle #(
      .IMEM_AW  (IMEM_AW),
      .DMEM_AW  (DMEM_AW),
      .RESET_PC (32'h0)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_data  (imem_data),
      .halted     (halted),
      .result     (result),
      .retired    (retired),
      .illegal    (illegal)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // ---------------- program store and reference model state ---------------
   logic [31:0] prog   [64];
   logic [31:0] m_rf   [32];
   logic [31:0] m_dmem [2**DMEM_AW];
   logic [31:0] m_result;
   logic [31:0] m_retired;
   logic [31:0] m_illegal;
   int          m_cycles;
   int          exp_fetch[$];
   int          last_cycles;

   function automatic logic [31:0] enc_r(input int f, input int rs, input int rt, input int rd, input int sh);
      return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], f[5:0]};
   endfunction
   function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
      return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
   endfunction
   function automatic logic [31:0] enc_j(input int tgt);
      return {6'd2, tgt[25:0]};
   endfunction
   function automatic logic [31:0] enc_brk(input int rs);
      return {6'd0, rs[4:0], 15'd0, 6'd13};
   endfunction

   task automatic fill_prog(input logic [31:0] w);
      for (int i = 0; i < 64; i++) prog[i] = w;
   endtask

   // Instruction-set interpreter: one loop iteration per instruction
   task automatic model_run(input int delay);
      logic [31:0] pc, ir, a, b, se, ze, pc4, npc, addr;
      int          steps;
      bit          done;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_result = 0; m_retired = 0; m_illegal = 0; m_cycles = 0;
      exp_fetch.delete();
      pc = 32'd0; done = 0; steps = 0;
      while (!done && steps < 1000) begin
         steps++;
         exp_fetch.push_back(int'(pc[IMEM_AW+1:2]));
         ir  = prog[pc[IMEM_AW+1:2]];
         a   = m_rf[ir[25:21]];
         b   = m_rf[ir[20:16]];
         se  = {{16{ir[15]}}, ir[15:0]};
         ze  = {16'h0, ir[15:0]};
         pc4 = pc + 32'd4;
         npc = pc4;
         m_retired++;
         m_cycles += 1 + delay;
         case (ir[31:26])
            6'd0: begin
               m_cycles += 3;
               case (ir[5:0])
                  6'd32: m_rf[ir[15:11]] = a + b;
                  6'd34: m_rf[ir[15:11]] = a - b;
                  6'd36: m_rf[ir[15:11]] = a & b;
                  6'd37: m_rf[ir[15:11]] = a | b;
                  6'd42: m_rf[ir[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                  6'd0:  m_rf[ir[15:11]] = b << ir[10:6];
                  6'd2:  m_rf[ir[15:11]] = b >> ir[10:6];
                  6'd13: begin m_result = a; done = 1; m_cycles -= 1; end
                  default: begin m_illegal = 1; m_cycles -= 1; end
               endcase
            end
            6'd8:  begin m_rf[ir[20:16]] = a + se; m_cycles += 3; end
            6'd12: begin m_rf[ir[20:16]] = a & ze; m_cycles += 3; end
            6'd13: begin m_rf[ir[20:16]] = a | ze; m_cycles += 3; end
            6'd35: begin
               addr = a + se;
               m_rf[ir[20:16]] = m_dmem[addr[DMEM_AW+1:2]];
               m_cycles += 4;
            end
            6'd43: begin
               addr = a + se;
               m_dmem[addr[DMEM_AW+1:2]] = b;
               m_cycles += 3;
            end
            6'd4: begin if (a == b) npc = pc4 + (se << 2); m_cycles += 2; end
            6'd5: begin if (a != b) npc = pc4 + (se << 2); m_cycles += 2; end
            6'd2: begin npc = {pc4[31:28], ir[25:0], 2'b00}; m_cycles += 2; end
            default: begin m_illegal = 1; m_cycles += 2; end
         endcase
         m_rf[0] = 32'd0;
         pc = npc;
      end
   endtask

   // Drives reset then the fetch responder; abort_at>0 reasserts reset
   // during that cycle and ends the run without end-of-run checks.
   task automatic dut_run(input string name, input int delay, input int abort_at);
      int                 k, waits;
      bit                 done;
      logic [IMEM_AW-1:0] held;
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clock); #1;
         check({name, " req_in_reset"}, 32'(imem_req), 32'd0);
         imem_valid = 1'($urandom_range(0, 1));
         imem_data  = $urandom;
         @(posedge clock); #1;
      end
      check({name, " rst_halted"},  32'(halted),  32'd0);
      check({name, " rst_retired"}, retired,      32'd0);
      check({name, " rst_illegal"}, 32'(illegal), 32'd0);
      check({name, " rst_result"},  result,       32'd0);
      reset = 1'b0;
      k = 1; waits = 0; done = 0; held = '0; last_cycles = -1;
      while (!done && k <= LIMIT) begin
         if (k == abort_at) reset = 1'b1;
         @(negedge clock); #1;
         if (k == 1 && abort_at == 0) begin
            check({name, " first_req"},  32'(imem_req),  32'd1);
            check({name, " first_addr"}, 32'(imem_addr), 32'd0);
         end
         if (halted) begin
            last_cycles = k - 1;
            done = 1;
         end else if (imem_req) begin
            if (waits == 0) held = imem_addr;
            else check({name, " addr_stable"}, 32'(imem_addr), 32'(held));
            if (waits == delay) begin
               imem_valid = 1'b1;
               imem_data  = prog[imem_addr];
               waits = 0;
               if (abort_at == 0) begin
                  if (exp_fetch.size() == 0)
                     check({name, " extra_fetch"}, 32'(imem_addr), 32'hFFFF_FFFF);
                  else
                     check({name, " fetch_addr"}, 32'(imem_addr), 32'(exp_fetch.pop_front()));
               end
            end else begin
               imem_valid = 1'b0;
               imem_data  = $urandom;
               waits++;
            end
         end else begin
            // spurious pulses while no request is outstanding
            imem_valid = ($urandom_range(0, 3) == 0);
            imem_data  = $urandom;
         end
         if (k == abort_at) done = 1;
         @(posedge clock); #1;
         k++;
      end
      if (abort_at != 0) return;
      if (!done) begin
         check({name, " timeout_halted"}, 32'(halted), 32'd1);
         return;
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clock); #1;
         check({name, " req_in_halt"}, 32'(imem_req), 32'd0);
         imem_valid = 1'($urandom_range(0, 1));
         imem_data  = $urandom;
      end
      check({name, " result"},      result,          m_result);
      check({name, " retired"},     retired,         m_retired);
      check({name, " illegal"},     32'(illegal),    m_illegal);
      check({name, " cycles"},      32'(last_cycles), 32'(m_cycles));
      check({name, " fetch_left"},  32'(exp_fetch.size()), 32'd0);
   endtask

   task automatic run(input string name, input int delay);
      model_run(delay);
      dut_run(name, delay, 0);
   endtask

   function automatic logic [31:0] rand_instr();
      int sel, rs, rt, rd, mimm;
      sel  = $urandom_range(0, 9);
      rs   = $urandom_range(0, 7);
      rt   = $urandom_range(0, 7);
      rd   = $urandom_range(0, 7);
      mimm = ($urandom_range(0, 63) << 9) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      case (sel)
         0, 1, 2: begin
            case ($urandom_range(0, 6))
               0: return enc_r(32, rs, rt, rd, $urandom_range(0, 31));
               1: return enc_r(34, rs, rt, rd, $urandom_range(0, 31));
               2: return enc_r(36, rs, rt, rd, $urandom_range(0, 31));
               3: return enc_r(37, rs, rt, rd, $urandom_range(0, 31));
               4: return enc_r(42, rs, rt, rd, $urandom_range(0, 31));
               5: return enc_r(0,  rs, rt, rd, $urandom_range(0, 31));
               default: return enc_r(2, rs, rt, rd, $urandom_range(0, 31));
            endcase
         end
         3: return enc_i(12, rs, rt, int'($urandom));
         4: return enc_i(13, rs, rt, int'($urandom));
         5: return enc_i(35, 0, rt, mimm);
         6: return enc_i(43, 0, rt, mimm);
         7: return enc_i($urandom_range(4, 5), rs, rt, $urandom_range(0, 2));
         8: return ($urandom_range(0, 1) == 0) ? 32'hFC00_0000 : enc_r(1, rs, rt, rd, 0);
         default: return enc_i(8, rs, rt, int'($urandom));
      endcase
   endfunction

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2**DMEM_AW; i++) m_dmem[i] = 32'd0;

      // Give the data words used below known contents
      fill_prog(enc_brk(0));
      for (int w = 0; w < 8; w++) prog[w] = enc_i(43, 0, 0, w * 4);
      prog[8] = enc_i(43, 0, 0, 17 * 4);
      run("init", 0);

      // ALU sequence, zero wait then 3 wait states per fetch
      fill_prog(enc_brk(0));
      prog[0] = enc_i(8, 0, 1, 5);
      prog[1] = enc_i(8, 0, 2, -3);
      prog[2] = enc_r(32, 1, 2, 3, 0);
      prog[3] = enc_r(42, 2, 1, 4, 0);
      prog[4] = enc_brk(3);
      run("alu", 0);
      check("alu_spec result",  result,           32'd2);
      check("alu_spec retired", retired,          32'd5);
      check("alu_spec cycles",  32'(last_cycles), 32'd19);
      run("alu_wait3", 3);
      check("alu_wait3_spec cycles", 32'(last_cycles), 32'd34);

      // Memory round trip
      fill_prog(enc_brk(0));
      prog[0] = enc_i(8, 0, 1, 32'h40);
      prog[1] = enc_i(43, 1, 1, 4);
      prog[2] = enc_i(35, 1, 2, 4);
      prog[3] = enc_brk(2);
      run("mem", 0);
      check("mem_spec result", result,           32'h40);
      check("mem_spec cycles", 32'(last_cycles), 32'd16);

      // Countdown loop, untaken beq, jump over two words
      fill_prog(enc_brk(0));
      prog[0] = enc_i(8, 0, 1, 3);
      prog[1] = enc_i(8, 0, 2, 1);
      prog[2] = enc_i(8, 0, 3, 7);
      prog[3] = enc_i(8, 1, 1, -1);
      prog[4] = enc_i(5, 1, 0, -2);
      prog[5] = enc_i(4, 1, 2, 5);
      prog[6] = enc_j(8);
      prog[7] = enc_i(8, 0, 1, 99);
      prog[8] = enc_brk(1);
      run("ctrl", 0);
      check("ctrl_spec result",  result,  32'd0);
      check("ctrl_spec retired", retired, 32'd12);

      // $0 write discard and an illegal opcode
      fill_prog(enc_brk(0));
      prog[0] = enc_i(8, 0, 0, 7);
      prog[1] = 32'hFC00_0000;
      prog[2] = enc_brk(0);
      run("corner", 0);
      check("corner_spec illegal", 32'(illegal), 32'd1);
      check("corner_spec retired", retired,      32'd3);

      // Reset landing on the MEM cycle of a store (cycle 12 with zero wait)
      fill_prog(enc_brk(0));
      prog[0] = enc_i(8, 0, 1, 32'h40);
      prog[1] = enc_i(8, 0, 2, 99);
      prog[2] = enc_i(43, 1, 2, 4);
      dut_run("abort_sw", 0, 12);
      fill_prog(enc_brk(0));
      prog[0] = enc_i(8, 0, 1, 32'h40);
      prog[1] = enc_i(35, 1, 3, 4);
      prog[2] = enc_brk(3);
      run("after_abort", 0);
      check("after_abort_spec result", result, 32'h40);

      // Randomized straight-line programs with forward branches
      for (int r = 0; r < 20; r++) begin
         fill_prog(enc_brk($urandom_range(0, 7)));
         for (int w = 0; w < 12; w++) prog[w] = rand_instr();
         run($sformatf("rand%0d", r), $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
